// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the pipelined on-chip memory slave.
// Byte-enable expansion is sized for the widest supported word (1024 bits).
package onchip_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_state_t;

    localparam int unsigned MIN_RL    = 1;
    localparam int unsigned MAX_RL    = 2;
    localparam int unsigned MAX_BYTES = 128;

    function automatic logic [MAX_BYTES*8-1:0] be_mask(input logic [MAX_BYTES-1:0] be);
        logic [MAX_BYTES*8-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/onchip_mem_ram.sv
// Single-port, read-first, bit-masked RAM with clock enable and registered read.
// The read register only updates on a read, so it doubles as the held output.
module onchip_mem_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wmask,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         addr,
    input  logic                  re,
    input  logic                  rzero,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (ce && we) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        end
    end

    // Sees the pre-write contents in the same cycle: read-first.
    always_comb begin
        rdata_d = rdata_q;
        if (ce && re) begin
            rdata_d = rzero ? '0 : mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM on-chip RAM slave with 1/2-cycle read pipeline, waitrequest
// back-pressure and a zero-fill engine run after reset or on request.
module onchip_memory_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned DEPTH          = 15000,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic                    freeze,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic                    clear_start,
    output logic                    clear_busy
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t            state_q, state_d;
    logic                  init_q, init_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  v1_q, v1_d;

    logic                  en;
    logic                  clearing;
    logic                  in_range;
    logic                  accept;
    logic                  wr_bus;
    logic                  rd_acc;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wmask;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign en          = clken & ~reset_req;
    assign clearing    = (state_q == CLEAR);
    assign clear_busy  = clearing;
    assign waitrequest = clearing | ~clken | reset_req | reset;
    assign in_range    = 32'(address) < 32'(DEPTH);
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign wr_bus      = accept & write & ~freeze & in_range;
    assign rd_acc      = accept & read & ~write;

    assign ram_we    = clearing | wr_bus;
    assign ram_wmask = clearing ? '1 : DATA_WIDTH'(be_mask(MAX_BYTES'(byteenable)));
    assign ram_wdata = clearing ? '0 : writedata;
    assign ram_addr  = RAM_AW'(clearing ? cnt_q : address);

    // init_q marks the first edge after reset release, which picks the post-reset state.
    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        cnt_d   = cnt_q;
        if (init_q) begin
            init_d  = 1'b0;
            cnt_d   = '0;
            state_d = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end
                end
                CLEAR: begin
                    if (en) begin
                        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        v1_d = en ? rd_acc : v1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            init_q  <= 1'b1;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
        end
    end

    onchip_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .ce    (en),
        .we    (ram_we),
        .wmask (ram_wmask),
        .wdata (ram_wdata),
        .addr  (ram_addr),
        .re    (rd_acc),
        .rzero (~in_range),
        .rdata (ram_rdata)
    );

    if (READ_LATENCY >= MAX_RL) begin : g_rl2
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
        logic                  rdv_q, rdv_d;

        always_comb begin
            rdv_d   = en ? v1_q : rdv_q;
            rdata_d = (en && v1_q) ? ram_rdata : rdata_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_q <= '0;
                rdv_q   <= 1'b0;
            end else begin
                rdata_q <= rdata_d;
                rdv_q   <= rdv_d;
            end
        end

        assign readdata      = rdata_q;
        assign readdatavalid = rdv_q;
    end else begin : g_rl1
        assign readdata      = ram_rdata;
        assign readdatavalid = v1_q;
    end

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Directed bench for onchip_memory_pipelined: three instances cover RL=1 with
// a 16-word clear, RL=2 with a 16-word clear, and a 15000-word part without clear.
module tb_onchip_memory_pipelined;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_i  [N];
    logic        rreq_i [N];
    logic        cken_i [N];
    logic        frz_i  [N];
    logic        cs_i   [N];
    logic        rd_i   [N];
    logic        wr_i   [N];
    logic        cst_i  [N];
    logic [13:0] addr_i [N];
    logic [31:0] wd_i   [N];
    logic [3:0]  be_i   [N];
    logic [31:0] rdata_o[N];
    logic        rdv_o  [N];
    logic        wait_o [N];
    logic        busy_o [N];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    onchip_memory_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .reset(rst_i[0]), .reset_req(rreq_i[0]), .clken(cken_i[0]),
        .freeze(frz_i[0]), .chipselect(cs_i[0]), .address(addr_i[0]), .read(rd_i[0]),
        .write(wr_i[0]), .writedata(wd_i[0]), .byteenable(be_i[0]), .readdata(rdata_o[0]),
        .readdatavalid(rdv_o[0]), .waitrequest(wait_o[0]), .clear_start(cst_i[0]),
        .clear_busy(busy_o[0])
    );

    onchip_memory_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .reset(rst_i[1]), .reset_req(rreq_i[1]), .clken(cken_i[1]),
        .freeze(frz_i[1]), .chipselect(cs_i[1]), .address(addr_i[1]), .read(rd_i[1]),
        .write(wr_i[1]), .writedata(wd_i[1]), .byteenable(be_i[1]), .readdata(rdata_o[1]),
        .readdatavalid(rdv_o[1]), .waitrequest(wait_o[1]), .clear_start(cst_i[1]),
        .clear_busy(busy_o[1])
    );

    onchip_memory_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(15000), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
    ) dut2 (
        .clk(clk), .reset(rst_i[2]), .reset_req(rreq_i[2]), .clken(cken_i[2]),
        .freeze(frz_i[2]), .chipselect(cs_i[2]), .address(addr_i[2]), .read(rd_i[2]),
        .write(wr_i[2]), .writedata(wd_i[2]), .byteenable(be_i[2]), .readdata(rdata_o[2]),
        .readdatavalid(rdv_o[2]), .waitrequest(wait_o[2]), .clear_start(cst_i[2]),
        .clear_busy(busy_o[2])
    );

    typedef struct {
        bit          is_wr;
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          frz;
        logic [31:0] exp;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input int d, input int a, input logic [31:0] data,
                             input logic [3:0] be, input logic frz, input string name);
        cs_i[d] = 1'b1; wr_i[d] = 1'b1; addr_i[d] = 14'(a);
        wd_i[d] = data; be_i[d] = be; frz_i[d] = frz;
        #1 chk({name, "_wait"}, 32'(wait_o[d]), 32'd0);
        @(negedge clk);
        cs_i[d] = 1'b0; wr_i[d] = 1'b0; frz_i[d] = 1'b0;
    endtask

    task automatic bus_read(input int d, input int a, input logic [31:0] exp,
                            input int rl, input string name);
        cs_i[d] = 1'b1; rd_i[d] = 1'b1; addr_i[d] = 14'(a);
        #1 chk({name, "_wait"}, 32'(wait_o[d]), 32'd0);
        @(negedge clk);
        cs_i[d] = 1'b0; rd_i[d] = 1'b0;
        for (int k = 1; k < rl; k++) begin
            chk({name, "_early"}, 32'(rdv_o[d]), 32'd0);
            @(negedge clk);
        end
        chk({name, "_valid"}, 32'(rdv_o[d]), 32'd1);
        chk({name, "_data"}, rdata_o[d], exp);
        @(negedge clk);
        chk({name, "_vdrop"}, 32'(rdv_o[d]), 32'd0);
        chk({name, "_hold"}, rdata_o[d], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt1, w0, c;

        for (int d = 0; d < N; d++) begin
            rst_i[d] = 1'b1; rreq_i[d] = 1'b0; cken_i[d] = 1'b1; frz_i[d] = 1'b0;
            cs_i[d] = 1'b0; rd_i[d] = 1'b0; wr_i[d] = 1'b0; cst_i[d] = 1'b0;
            addr_i[d] = '0; wd_i[d] = '0; be_i[d] = '0;
        end

        tv[0]  = '{1, 3,  32'hAABBCCDD, 4'b0101, 0, 32'h0};
        tv[1]  = '{0, 3,  32'h0,        4'b0000, 0, 32'h00BB00DD};
        tv[2]  = '{1, 3,  32'h01020304, 4'b1010, 0, 32'h0};
        tv[3]  = '{0, 3,  32'h0,        4'b0000, 0, 32'h01BB03DD};
        tv[4]  = '{1, 4,  32'h11223344, 4'b1111, 0, 32'h0};
        tv[5]  = '{0, 4,  32'h0,        4'b0000, 0, 32'h11223344};
        tv[6]  = '{1, 0,  32'hFFFFFFFF, 4'b1111, 1, 32'h0};
        tv[7]  = '{0, 0,  32'h0,        4'b0000, 0, 32'h00000000};
        tv[8]  = '{1, 19, 32'hDEADBEEF, 4'b1111, 0, 32'h0};
        tv[9]  = '{0, 3,  32'h0,        4'b0000, 0, 32'h01BB03DD};
        tv[10] = '{0, 19, 32'h0,        4'b0000, 0, 32'h00000000};
        tv[11] = '{0, 15, 32'h0,        4'b0000, 0, 32'h00000000};
        tv[12] = '{1, 15, 32'hCAFEF00D, 4'b1111, 0, 32'h0};
        tv[13] = '{0, 15, 32'h0,        4'b0000, 0, 32'hCAFEF00D};
        tv[14] = '{1, 2,  32'h00000055, 4'b0000, 0, 32'h0};
        tv[15] = '{0, 2,  32'h0,        4'b0000, 0, 32'h00000000};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            chk($sformatf("rst_rdata%0d", d), rdata_o[d], 32'h0);
            chk($sformatf("rst_rdv%0d", d), 32'(rdv_o[d]), 32'd0);
            chk($sformatf("rst_wait%0d", d), 32'(wait_o[d]), 32'd1);
            chk($sformatf("rst_busy%0d", d), 32'(busy_o[d]), 32'd0);
        end

        // Post-reset clear: exactly DEPTH busy cycles
        rst_i[0] = 1'b0; rst_i[1] = 1'b0; rst_i[2] = 1'b0;
        cnt0 = 0; cnt1 = 0; w0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_o[0]) cnt0++;
            if (busy_o[0] && wait_o[0]) w0++;
            if (busy_o[1]) cnt1++;
            if (i == 0) begin
                chk("noclr_busy", 32'(busy_o[2]), 32'd0);
                chk("noclr_wait", 32'(wait_o[2]), 32'd0);
            end
        end
        chk("clr_cycles0", 32'(cnt0), 32'd16);
        chk("clr_wait0", 32'(w0), 32'd16);
        chk("clr_cycles1", 32'(cnt1), 32'd16);
        bus_read(0, 5, 32'h0, 1, "rd5_cleared");

        // Table-driven single transfers on the RL=1 instance
        for (int i = 0; i < 16; i++) begin
            if (tv[i].is_wr)
                bus_write(0, tv[i].addr, tv[i].data, tv[i].be, tv[i].frz, $sformatf("tv%0d_wr", i));
            else
                bus_read(0, tv[i].addr, tv[i].exp, 1, $sformatf("tv%0d_rd", i));
        end

        // Back-to-back reads 3,4,3
        cs_i[0] = 1'b1; rd_i[0] = 1'b1; addr_i[0] = 14'd3;
        @(negedge clk);
        addr_i[0] = 14'd4;
        chk("b2b_v0", 32'(rdv_o[0]), 32'd1); chk("b2b_d0", rdata_o[0], 32'h01BB03DD);
        @(negedge clk);
        addr_i[0] = 14'd3;
        chk("b2b_v1", 32'(rdv_o[0]), 32'd1); chk("b2b_d1", rdata_o[0], 32'h11223344);
        @(negedge clk);
        cs_i[0] = 1'b0; rd_i[0] = 1'b0;
        chk("b2b_v2", 32'(rdv_o[0]), 32'd1); chk("b2b_d2", rdata_o[0], 32'h01BB03DD);
        @(negedge clk);
        chk("b2b_end", 32'(rdv_o[0]), 32'd0);

        // Read and write together: write wins, no response
        cs_i[0] = 1'b1; rd_i[0] = 1'b1; wr_i[0] = 1'b1; addr_i[0] = 14'd6;
        wd_i[0] = 32'h00000066; be_i[0] = 4'hF;
        @(negedge clk);
        cs_i[0] = 1'b0; rd_i[0] = 1'b0; wr_i[0] = 1'b0;
        chk("rw_novalid0", 32'(rdv_o[0]), 32'd0);
        @(negedge clk);
        chk("rw_novalid1", 32'(rdv_o[0]), 32'd0);
        bus_read(0, 6, 32'h00000066, 1, "rw_rd6");

        // reset_req blocks accesses
        rreq_i[0] = 1'b1; cs_i[0] = 1'b1; wr_i[0] = 1'b1; addr_i[0] = 14'd4;
        wd_i[0] = 32'h0; be_i[0] = 4'hF;
        #1 chk("rreq_wait", 32'(wait_o[0]), 32'd1);
        repeat (2) @(negedge clk);
        rreq_i[0] = 1'b0; cs_i[0] = 1'b0; wr_i[0] = 1'b0;
        bus_read(0, 4, 32'h11223344, 1, "rreq_rd4");

        // RL=2 instance: latency, pipelining and clken stall
        bus_write(1, 7, 32'h12345678, 4'hF, 1'b0, "l2_wr7");
        bus_write(1, 8, 32'h0BADF00D, 4'hF, 1'b0, "l2_wr8");
        bus_read(1, 7, 32'h12345678, 2, "l2_rd7");
        cs_i[1] = 1'b1; rd_i[1] = 1'b1; addr_i[1] = 14'd7;
        @(negedge clk);
        addr_i[1] = 14'd8;
        chk("l2p_v0", 32'(rdv_o[1]), 32'd0);
        @(negedge clk);
        cs_i[1] = 1'b0; rd_i[1] = 1'b0;
        chk("l2p_v1", 32'(rdv_o[1]), 32'd1); chk("l2p_d1", rdata_o[1], 32'h12345678);
        @(negedge clk);
        chk("l2p_v2", 32'(rdv_o[1]), 32'd1); chk("l2p_d2", rdata_o[1], 32'h0BADF00D);
        @(negedge clk);
        chk("l2p_end", 32'(rdv_o[1]), 32'd0);

        cs_i[1] = 1'b1; rd_i[1] = 1'b1; addr_i[1] = 14'd7;
        @(negedge clk);
        cs_i[1] = 1'b0; rd_i[1] = 1'b0; cken_i[1] = 1'b0;
        #1 chk("stall_wait", 32'(wait_o[1]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_v%0d", i), 32'(rdv_o[1]), 32'd0);
        end
        cken_i[1] = 1'b1;
        @(negedge clk);
        chk("stall_valid", 32'(rdv_o[1]), 32'd1);
        chk("stall_data", rdata_o[1], 32'h12345678);
        @(negedge clk);
        chk("stall_vdrop", 32'(rdv_o[1]), 32'd0);

        // DEPTH=15000 boundary
        bus_write(2, 14999, 32'h5A5A5A5A, 4'hF, 1'b0, "big_wr_last");
        bus_read(2, 14999, 32'h5A5A5A5A, 1, "big_rd_last");
        bus_write(2, 15000, 32'h12345678, 4'hF, 1'b0, "big_wr_oor");
        bus_read(2, 15000, 32'h0, 1, "big_rd_oor");
        bus_read(2, 14999, 32'h5A5A5A5A, 1, "big_rd_last2");

        // Reset in the middle of a requested clear, then a fresh fill
        bus_read(0, 3, 32'h01BB03DD, 1, "pre_clr_rd3");
        cst_i[0] = 1'b1;
        c = 0;
        for (int i = 0; i < 40 && c < 8; i++) begin
            @(negedge clk);
            cst_i[0] = 1'b0;
            if (busy_o[0]) c++;
        end
        chk("clr_reach8", 32'(c), 32'd8);
        #2 rst_i[0] = 1'b1;
        #1;
        chk("async_busy", 32'(busy_o[0]), 32'd0);
        chk("async_wait", 32'(wait_o[0]), 32'd1);
        chk("async_rdv", 32'(rdv_o[0]), 32'd0);
        chk("async_rdata", rdata_o[0], 32'h0);
        @(negedge clk);
        rst_i[0] = 1'b0;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cst_i[0] = 1'b0;
            if (busy_o[0]) begin
                c++;
                if (c == 4) cst_i[0] = 1'b1;
            end
        end
        chk("refill_cycles", 32'(c), 32'd16);
        bus_read(0, 3, 32'h0, 1, "post_clr_rd3");
        bus_read(0, 15, 32'h0, 1, "post_clr_rd15");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_memory_pipelined.md
Name: onchip_memory_pipelined

Overview:
Parametrised successor to the team's single-port Avalon-MM on-chip RAM slave. It adds configurable data width and depth, a 1- or 2-cycle registered read pipeline with readdatavalid, and waitrequest back-pressure. A clear engine zero-fills the array after reset or on request. It sits on the Qsys/Avalon fabric as a scratch or frame-line buffer for the vision pipeline and the Nios software.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of 8.
ADDR_WIDTH, 14, word-address width.
DEPTH, 15000, number of implemented words; must satisfy DEPTH <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values are 1 or 2.
CLEAR_ON_RESET, 1, when 1 the array is zero-filled automatically after reset release.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-high reset.
reset_req  in  1  reset-request; while high, no accesses are accepted.
clken  in  1  clock enable; while low, the block stalls.
freeze  in  1  suppresses writes while high.
chipselect  in  1  Avalon slave select.
address  in  ADDR_WIDTH  word address.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
byteenable  in  DATA_WIDTH/8  per-byte write enable.
readdata  out  DATA_WIDTH  read data, registered.
readdatavalid  out  1  one-cycle pulse qualifying readdata.
waitrequest  out  1  back-pressure.
clear_start  in  1  pulse that starts a zero-fill.
clear_busy  out  1  high while the zero-fill runs.

Behaviour:
- Reset (asynchronous): readdata=0, readdatavalid=0, waitrequest=1, clear_busy=0. FSM goes to IDLE, clear counter=0, read pipeline is flushed.
- FSM states are IDLE and CLEAR.
  - On the first clk after reset release: go to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
  - IDLE -> CLEAR on clear_start=1.
  - CLEAR writes 0 to address cnt each enabled cycle. cnt runs 0..DEPTH-1, then the FSM returns to IDLE with cnt=0.
  - A zero-fill takes exactly DEPTH enabled cycles. clear_busy=1 throughout CLEAR.
  - clear_start while in CLEAR is ignored.
  - Reset during CLEAR aborts the fill. If CLEAR_ON_RESET=1, a fresh fill restarts from address 0.
- waitrequest = (state==CLEAR) | ~clken | reset_req | reset. It is combinational from these inputs and the state register.
- A transfer is accepted when chipselect & (read|write) & ~waitrequest.
- Write: byte i is updated iff byteenable[i]=1. The write is dropped if freeze=1 or address>=DEPTH. A dropped write is still accepted, so there is no hang.
- Read:
  - For an accepted read at cycle T, readdata is valid and readdatavalid=1 exactly at cycle T+READ_LATENCY.
  - One read can be accepted per cycle, giving full throughput. Responses return in order.
  - address>=DEPTH returns 0.
  - readdata holds its last value when readdatavalid=0.
- read and write asserted together: the write is performed, the read is ignored and no readdatavalid is produced.
- Read of an address written in the same cycle returns the old data (read-first). A read in the cycle after the write returns the new data.
- With clken=0 or reset_req=1:
  - the pipeline freezes and the array is not written;
  - pending readdatavalid pulses are held until enable returns;
  - the CLEAR counter also holds.
- freeze does not affect reads or CLEAR.

Decomposition:
- Package onchip_mem_pkg holds:
  - the state enum, mem_state_t {IDLE, CLEAR};
  - the legal-latency constants MIN_RL=1 and MAX_RL=2;
  - the function be_mask(byteenable) → DATA_WIDTH bit mask.
- One sub-module, onchip_mem_ram: an inferred single-port, read-first, byte-enabled RAM (DATA_WIDTH x DEPTH) with a clock enable.
- The top level owns the FSM, the address mux between clear counter and bus, range checking, and the latency pipeline.

Test Plan:
1. Reset release with CLEAR_ON_RESET=1, DEPTH=16 -> clear_busy=1 and waitrequest=1 for exactly 16 cycles. A read of address 5 afterwards returns 0x00000000 with readdatavalid at T+1.
2. Write 0xAABBCCDD to address 3 with byteenable=4'b0101, over a cleared word -> a read of address 3 returns 0x00BB00DD. Reads of addresses 3, 4, 3 issued back-to-back give three valid pulses in order.
3. READ_LATENCY=2: write 0x12345678 to address 7, then read 7 -> readdatavalid exactly 2 cycles after the read, readdata=0x12345678. Drop clken for 3 cycles mid-flight -> the valid pulse is delayed by 3 cycles.
4. freeze=1, write 0xFFFFFFFF to address 0 -> the write is accepted without waitrequest. A later read of address 0 returns 0x00000000.
5. Out-of-range access with DEPTH=15000: write address 15000 → no array change; read address 15000 → readdata=0, readdatavalid=1.
6. Assert reset at cycle 8 of a 16-word clear -> outputs return to reset values asynchronously. After release, clear_busy stays high for 16 fresh cycles. clear_start pulsed during CLEAR does not extend the fill.
